// File: rtl/program_loader_if.sv
// Bundle of the byte-stream input, CPU fetch port and loader status signals.
// The master side feeds bytes and fetch addresses; the slave side is the loader.
interface program_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [31:0] rom_address;
    logic [31:0] rom_data;
    logic        cpu_enable;
    logic        busy;
    logic        error;
    logic [15:0] word_count;

    modport master (
        output rx_data,
        output rx_valid,
        output rom_address,
        input  rom_data,
        input  cpu_enable,
        input  busy,
        input  error,
        input  word_count
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rom_address,
        output rom_data,
        output cpu_enable,
        output busy,
        output error,
        output word_count
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed, XOR-checksummed byte stream into
// instruction memory, then releases the CPU or latches an error until reset.
module program_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int TIMEOUT     = 100000
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  bus
);
    localparam int          AW           = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP          = 32'h0000_0013;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
    localparam logic [16:0] DEPTH_W      = 17'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CHECK  = 3'd3,
        S_RUN    = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    len_lo_q, len_lo_d;
    logic [15:0]   word_count_q, word_count_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [15:0]   word_idx_q, word_idx_d;
    logic [7:0]    csum_q, csum_d;
    logic [23:0]   asm_q, asm_d;
    logic [31:0]   idle_cnt_q, idle_cnt_d;
    logic          cpu_enable_q, busy_q, error_q;

    logic [31:0]            mem_q [DEPTH_WORDS];
    logic [DEPTH_WORDS-1:0] valid_q;

    logic          mem_we_s;
    logic          clr_valid_s;
    logic [31:0]   mem_wdata_s;
    logic [15:0]   len_s;
    logic [15:0]   last_word_s;
    logic          timeout_s;
    logic          rom_in_range_s;
    logic [AW-1:0] rom_idx_s;
    logic          unused_addr_s;

    assign len_s          = {bus.rx_data, len_lo_q};
    assign last_word_s    = word_count_q - 16'd1;
    assign timeout_s      = (idle_cnt_q == TIMEOUT_LAST);
    assign mem_wdata_s    = {bus.rx_data, asm_q};
    assign rom_in_range_s = (bus.rom_address[31:2] < 30'(DEPTH_WORDS));
    assign rom_idx_s      = bus.rom_address[AW+1:2];
    assign unused_addr_s  = ^bus.rom_address[1:0];

    // Next-state and datapath updates for the load sequence.
    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        word_count_d = word_count_q;
        byte_idx_d   = byte_idx_q;
        word_idx_d   = word_idx_q;
        csum_d       = csum_q;
        asm_d        = asm_q;
        idle_cnt_d   = idle_cnt_q;
        mem_we_s     = 1'b0;
        clr_valid_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                idle_cnt_d = 32'd0;
                if (bus.rx_valid) begin
                    len_lo_d    = bus.rx_data;
                    clr_valid_s = 1'b1;
                    state_d     = S_LEN_HI;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEN_HI: begin
                if (bus.rx_valid) begin
                    word_count_d = len_s;
                    byte_idx_d   = 2'd0;
                    word_idx_d   = 16'd0;
                    csum_d       = 8'd0;
                    idle_cnt_d   = 32'd0;
                    if ({1'b0, len_s} > DEPTH_W) begin
                        state_d = S_ERROR;
                    end else if (len_s == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (timeout_s) begin
                    state_d = S_ERROR;
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    idle_cnt_d = 32'd0;
                    csum_d     = csum_q ^ bus.rx_data;
                    // Bytes shift in from the top so byte 0 lands in bits 7:0.
                    asm_d      = {bus.rx_data, asm_q[23:8]};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_we_s   = 1'b1;
                        word_idx_d = word_idx_q + 16'd1;
                        if (word_idx_q == last_word_s) begin
                            state_d = S_CHECK;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end else if (timeout_s) begin
                    state_d = S_ERROR;
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                end
            end
            S_CHECK: begin
                if (bus.rx_valid) begin
                    idle_cnt_d = 32'd0;
                    if (bus.rx_data == csum_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else if (timeout_s) begin
                    state_d = S_ERROR;
                end else begin
                    idle_cnt_d = idle_cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                idle_cnt_d = 32'd0;
                state_d    = S_RUN;
            end
            S_ERROR: begin
                idle_cnt_d = 32'd0;
                state_d    = S_ERROR;
            end
            default: begin
                state_d = S_ERROR;
            end
        endcase
    end

    // State register with status outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            len_lo_q     <= 8'd0;
            word_count_q <= 16'd0;
            byte_idx_q   <= 2'd0;
            word_idx_q   <= 16'd0;
            csum_q       <= 8'd0;
            asm_q        <= 24'd0;
            idle_cnt_q   <= 32'd0;
            cpu_enable_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            word_count_q <= word_count_d;
            byte_idx_q   <= byte_idx_d;
            word_idx_q   <= word_idx_d;
            csum_q       <= csum_d;
            asm_q        <= asm_d;
            idle_cnt_q   <= idle_cnt_d;
            cpu_enable_q <= (state_d == S_RUN);
            busy_q       <= (state_d == S_LEN_HI) || (state_d == S_DATA) || (state_d == S_CHECK);
            error_q      <= (state_d == S_ERROR);
        end
    end

    // Per-word "written by this load" flags; stale words read back as NOP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (clr_valid_s) begin
            valid_q <= '0;
        end else if (mem_we_s) begin
            valid_q[word_idx_q[AW-1:0]] <= 1'b1;
        end else begin
            valid_q <= valid_q;
        end
    end

    // Instruction memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (rst && mem_we_s) begin
            mem_q[word_idx_q[AW-1:0]] <= mem_wdata_s;
        end
    end

    assign bus.rom_data   = (rom_in_range_s && valid_q[rom_idx_s]) ? mem_q[rom_idx_s] : NOP;
    assign bus.cpu_enable = cpu_enable_q;
    assign bus.busy       = busy_q;
    assign bus.error      = error_q;
    assign bus.word_count = word_count_q;
endmodule
